// File: rtl/ula_issue_pkg.sv
// Shared definitions for the ula issue stage: ALU op codes, RISC-V opcodes, FSM states.
package ula_issue_pkg;

  typedef enum logic [3:0] {
    ULA_AND = 4'b0000,
    ULA_OR  = 4'b0001,
    ULA_ADD = 4'b0010,
    ULA_SUB = 4'b0110
  } ula_op_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/ula_issue_if.sv
// Handshake bundle between decode, the issue stage and the writeback/branch consumer.
interface ula_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      in_opcode;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_imm;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic            out_err;
  logic [4:0]      out_rd;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, in_rd,
    input  out_ready,
    output in_ready, out_valid, out_result, out_zero, out_err, out_rd
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7b5, in_rs1, in_rs2, in_imm, in_rd,
    output out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_err, out_rd
  );
endinterface

// File: rtl/ula.sv
// Combinational ALU: AND, OR, ADD, SUB modulo 2^XLEN.
module ula
  import ula_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic signed [XLEN-1:0] A,
  input  logic signed [XLEN-1:0] B,
  input  ula_op_t                UlaOp,
  output logic signed [XLEN-1:0] S
);

  always_comb begin
    S = '0;
    unique case (UlaOp)
      ULA_AND: S = A & B;
      ULA_OR:  S = A | B;
      ULA_ADD: S = A + B;
      ULA_SUB: S = A - B;
      default: S = '0;
    endcase
  end

endmodule

// File: rtl/ula_issue_ctrl.sv
// Combinational decode of opcode/funct3/funct7b5 into ALU op, B-operand select and illegal flag.
module ula_issue_ctrl
  import ula_issue_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output ula_op_t    op_o,
  output logic       use_imm_o,
  output logic       err_o
);

  always_comb begin
    op_o      = ULA_ADD;
    use_imm_o = 1'b1;
    err_o     = 1'b0;
    case (opcode_i)
      OP_R: begin
        use_imm_o = 1'b0;
        case (funct3_i)
          3'b000:  op_o = funct7b5_i ? ULA_SUB : ULA_ADD;
          3'b111:  op_o = ULA_AND;
          3'b110:  op_o = ULA_OR;
          default: err_o = 1'b1;
        endcase
      end
      OP_I: begin
        case (funct3_i)
          3'b000:  op_o = ULA_ADD;
          3'b111:  op_o = ULA_AND;
          3'b110:  op_o = ULA_OR;
          default: err_o = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: op_o = ULA_ADD;
      OP_BRANCH: begin
        op_o      = ULA_SUB;
        use_imm_o = 1'b0;
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ula_issue.sv
// Execute-stage front end: latch one decoded instruction, run the ula for one cycle,
// hold the registered result until the consumer takes it.
module ula_issue
  import ula_issue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  ula_issue_if.slave bus
);

  state_t          state_q, state_d;
  logic            in_ready, accept;

  logic [XLEN-1:0] a_q, b_q;
  ula_op_t         op_q;
  logic [4:0]      rd_q;
  logic            err_q;

  logic [XLEN-1:0] res_q;
  logic            zero_q, err_out_q;
  logic [4:0]      rd_out_q;

  ula_op_t         dec_op;
  logic            dec_use_imm, dec_err;
  logic [XLEN-1:0] s;

  ula_issue_ctrl u_ctrl (
    .opcode_i   (bus.in_opcode),
    .funct3_i   (bus.in_funct3),
    .funct7b5_i (bus.in_funct7b5),
    .op_o       (dec_op),
    .use_imm_o  (dec_use_imm),
    .err_o      (dec_err)
  );

  ula #(.XLEN(XLEN)) u_ula (
    .A     (a_q),
    .B     (b_q),
    .UlaOp (op_q),
    .S     (s)
  );

  always_comb begin
    in_ready = !rst && ((state_q == IDLE) || ((state_q == RESP) && bus.out_ready));
    accept   = bus.in_valid && in_ready;
    state_d  = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.out_ready) state_d = bus.in_valid ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latch: only the accepting edge samples the in_* fields.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= bus.in_rs1;
      b_q   <= dec_use_imm ? bus.in_imm : bus.in_rs2;
      op_q  <= dec_op;
      rd_q  <= bus.in_rd;
      err_q <= dec_err;
    end
  end

  // Result capture at the end of EXEC; an illegal op forces result 0 / zero 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q     <= '0;
      zero_q    <= 1'b0;
      err_out_q <= 1'b0;
      rd_out_q  <= '0;
    end else if (state_q == EXEC) begin
      res_q     <= err_q ? '0 : s;
      zero_q    <= err_q || (s == '0);
      err_out_q <= err_q;
      rd_out_q  <= rd_q;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == RESP);
  assign bus.out_result = res_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_err    = err_out_q;
  assign bus.out_rd     = rd_out_q;

endmodule

// File: tb/tb_ula_issue.sv
// Directed bench for ula_issue: hand-computed vectors over decode, handshake and reset.
module tb_ula_issue;
  import ula_issue_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ula_issue_if #(.XLEN(32)) bus ();

  ula_issue #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd);
    bus.in_valid    = 1'b1;
    bus.in_opcode   = opc;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = f7;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
    bus.in_rd       = rd;
  endtask

  task automatic scramble();
    bus.in_valid  = 1'b0;
    bus.in_opcode = 7'h7F;
    bus.in_funct3 = 3'h5;
    bus.in_rs1    = $urandom;
    bus.in_rs2    = $urandom;
    bus.in_imm    = $urandom;
    bus.in_rd     = 5'h1F;
  endtask

  // Issue one op from IDLE with out_ready=1; check latency, result and return to IDLE.
  task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic exp_zero, input logic exp_err);
    bus.out_ready = 1'b1;
    drive(opc, f3, f7, rs1, rs2, imm, rd);
    check_eq({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    step();
    scramble();
    check_eq({tag, ".valid_exec"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".in_ready_exec"}, 32'(bus.in_ready), 32'd0);
    step();
    check_eq({tag, ".valid_resp"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, ".result"}, bus.out_result, exp_res);
    check_eq({tag, ".zero"}, 32'(bus.out_zero), 32'(exp_zero));
    check_eq({tag, ".err"}, 32'(bus.out_err), 32'(exp_err));
    check_eq({tag, ".rd"}, 32'(bus.out_rd), 32'(rd));
    step();
    check_eq({tag, ".valid_after"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.out_ready = 1'b0;
    scramble();

    // Reset state
    step();
    check_eq("rst.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("rst.valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst.result", bus.out_result, 32'd0);
    check_eq("rst.zero", 32'(bus.out_zero), 32'd0);
    check_eq("rst.err", 32'(bus.out_err), 32'd0);
    check_eq("rst.rd", 32'(bus.out_rd), 32'd0);
    check_eq("rst.in_ready_idle", 32'(bus.in_ready), 32'd1);

    // Decode / ALU vectors
    run_op("r_add", OP_R, 3'b000, 1'b0, 32'd20, 32'd12, 32'd999, 5'd1, 32'd32, 1'b0, 1'b0);
    run_op("r_sub", OP_R, 3'b000, 1'b1, 32'd20, 32'd12, 32'd999, 5'd2, 32'd8, 1'b0, 1'b0);
    run_op("r_and", OP_R, 3'b111, 1'b0, 32'd20, 32'd12, 32'd999, 5'd3, 32'd4, 1'b0, 1'b0);
    run_op("r_or",  OP_R, 3'b110, 1'b0, 32'd20, 32'd12, 32'd999, 5'd4, 32'd28, 1'b0, 1'b0);
    run_op("br_eq", OP_BRANCH, 3'b001, 1'b0, 32'd7, 32'd7, 32'd55, 5'd6, 32'd0, 1'b1, 1'b0);
    run_op("br_ne", OP_BRANCH, 3'b000, 1'b0, 32'd7, 32'd9, 32'd55, 5'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("i_wrap", OP_I, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'd77, 32'd1, 5'd8, 32'd0, 1'b1, 1'b0);
    run_op("i_and", OP_I, 3'b111, 1'b0, 32'hF0F0_00FF, 32'd0, 32'h0000_0F0F, 5'd9, 32'h0000_000F, 1'b0, 1'b0);
    run_op("store", OP_STORE, 3'b010, 1'b0, 32'd100, 32'd5, 32'hFFFF_FFFC, 5'd10, 32'd96, 1'b0, 1'b0);
    run_op("load",  OP_LOAD, 3'b000, 1'b0, 32'h1000, 32'd5, 32'h0000_0024, 5'd11, 32'h1024, 1'b0, 1'b0);
    run_op("illegal", 7'b0110111, 3'b000, 1'b0, 32'd3, 32'd4, 32'd5, 5'd5, 32'd0, 1'b1, 1'b1);
    run_op("clr_err", OP_R, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 5'd12, 32'd3, 1'b0, 1'b0);

    // Back-pressure: outputs held for 5 cycles, then back-to-back accept on out_ready
    bus.out_ready = 1'b0;
    drive(OP_I, 3'b110, 1'b0, 32'h0000_00F0, 32'd0, 32'h0000_000F, 5'd13);
    step();
    scramble();
    step();
    for (int i = 0; i < 5; i++) begin
      check_eq("hold.valid", 32'(bus.out_valid), 32'd1);
      check_eq("hold.result", bus.out_result, 32'h0000_00FF);
      check_eq("hold.rd", 32'(bus.out_rd), 32'd13);
      check_eq("hold.in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    drive(OP_R, 3'b000, 1'b1, 32'd50, 32'd8, 32'd0, 5'd14);
    #1;
    check_eq("b2b.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    scramble();
    check_eq("b2b.valid_exec", 32'(bus.out_valid), 32'd0);
    step();
    check_eq("b2b.valid", 32'(bus.out_valid), 32'd1);
    check_eq("b2b.result", bus.out_result, 32'd42);
    check_eq("b2b.rd", 32'(bus.out_rd), 32'd14);
    step();

    // Reset during EXEC drops the op
    drive(OP_R, 3'b000, 1'b0, 32'd5, 32'd6, 32'd0, 5'd15);
    step();
    scramble();
    rst = 1'b1;
    #1;
    check_eq("rstx.in_ready", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check_eq("rstx.valid", 32'(bus.out_valid), 32'd0);
    check_eq("rstx.result", bus.out_result, 32'd0);
    check_eq("rstx.rd", 32'(bus.out_rd), 32'd0);
    check_eq("rstx.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    step();
    check_eq("rstx.no_output", 32'(bus.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
